// File: rtl/sm_fetch_buffer_pkg.sv
// Shared types and constants for the instruction-fetch buffer.
//   fetch_state_t : fetch FSM encoding (FETCH / HALT)
//   fetch_entry_t : one queued fetch result, {pc, instr}
//   PC_STEP       : byte increment between sequential fetches
//   word_addr()   : byte PC -> ROM word address
package sm_fetch_buffer_pkg;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic [31:0] word_addr(input logic [31:0] byte_pc);
    return {2'b00, byte_pc[31:2]};
  endfunction

endpackage

// File: rtl/sm_fifo_sync.sv
// Generic single-clock FIFO with combinational head output.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous flush (empties the FIFO, ignores push)
//   push     : write wdata (accepted when not full, or full with pop)
//   pop      : drop the head entry (ignored when empty)
//   wdata    : entry to write
//   rdata    : current head entry (stale contents when empty)
//   empty    : no entries held
//   count    : entries held, 0..DEPTH
module sm_fifo_sync #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]                 rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]                 count_reg, count_next;
  logic [DEPTH-1:0][WIDTH-1:0]   mem;
  logic                          do_push, do_pop;

  assign do_pop  = pop && (count_reg != '0);
  // A full FIFO can still accept a write when the head leaves in the same cycle:
  // the write lands in the slot the head is vacating.
  assign do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop)
      count_next = count_reg + CW'(1);
    else if (do_pop && !do_push)
      count_next = count_reg - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_pop)
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (do_push)
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      count_reg <= count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          entry_reg <= '0;
        else if (do_push && !clear && (wr_ptr_reg == PW'(gi)))
          entry_reg <= wdata;
      end
      assign mem[gi] = entry_reg;
    end
  endgenerate

  assign rdata = mem[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/sm_fetch_buffer.sv
// Instruction-fetch stage: owns the fetch PC, reads one ROM word per cycle and
// queues {pc, instr} pairs for decode behind a valid/ready handshake.
//   clk, rst        : clock, asynchronous active-high reset
//   fetch_en        : fetch allowed this cycle
//   rom_a / rom_rd  : combinational ROM word address / data
//   redirect_valid  : flush queue and restart at redirect_pc (bits [1:0] ignored)
//   instr_valid/ready, instr_data, instr_pc : decode-side stream (zeros when empty)
//   fetch_halted    : fetch stopped after reaching an out-of-range PC
module sm_fetch_buffer
  import sm_fetch_buffer_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          ROM_SIZE = 128,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] rom_a,
  input  logic [31:0] rom_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        fetch_halted
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state_reg;
  logic [31:0]   fetch_pc_reg;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  fetch_entry_t  head, wr_entry;
  logic          in_range, fetch_try, push, pop;

  assign in_range  = fetch_pc_reg[31:2] < 30'(ROM_SIZE);
  // Redirect outranks fetching: nothing is pushed in a redirect cycle.
  assign fetch_try = (state_reg == ST_FETCH) && fetch_en && !redirect_valid;
  assign pop       = !fifo_empty && instr_ready;
  assign push      = fetch_try && in_range && ((fifo_count < CW'(DEPTH)) || pop);
  assign wr_entry  = '{pc: fetch_pc_reg, instr: rom_rd};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_FETCH;
      fetch_pc_reg <= RESET_PC & ~32'h3;
    end else if (redirect_valid) begin
      state_reg    <= ST_FETCH;
      fetch_pc_reg <= redirect_pc & ~32'h3;
    end else if (push) begin
      fetch_pc_reg <= fetch_pc_reg + PC_STEP;
    end else if (fetch_try && !in_range) begin
      // Sticky until redirect/reset; entries already queued keep draining.
      state_reg <= ST_HALT;
    end
  end

  sm_fifo_sync #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rom_a        = word_addr(fetch_pc_reg);
  assign instr_valid  = !fifo_empty;
  assign instr_data   = fifo_empty ? 32'h0 : head.instr;
  assign instr_pc     = fifo_empty ? 32'h0 : head.pc;
  assign fetch_halted = (state_reg == ST_HALT);

endmodule
